// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode R-type fields, drive the ALU
// function code, pulse register write-back. Owns the program counter.
module multicycle_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [4:0]      rf_rs_addr,
    output logic [4:0]      rf_rt_addr,
    output logic [4:0]      rf_rd_addr,
    output logic            rf_we,
    output logic [3:0]      alu_op,
    output logic            busy,
    output logic            halted,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP  = PC_W'(4);
    localparam logic [3:0]      ALU_IDLE = 4'b1111;
    localparam logic [3:0]      FUNCT_MAX = 4'b1000;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     retired_q, retired_d;

    // Only the fields the sequencer consumes are kept; shamt bits are dropped.
    logic [5:0]      opcode_q, opcode_d;
    logic [4:0]      rs_q, rs_d;
    logic [4:0]      rt_q, rt_d;
    logic [4:0]      rd_q, rd_d;
    logic [3:0]      funct_q, funct_d;

    logic            legal;

    assign legal = (opcode_q == 6'b000000) && (funct_q <= FUNCT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        retired_d = retired_q;
        opcode_d  = opcode_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        funct_d   = funct_q;
        if (state_q == S_FETCH && imem_ack) begin
            opcode_d = imem_rdata[31:26];
            rs_d     = imem_rdata[25:21];
            rt_d     = imem_rdata[20:16];
            rd_d     = imem_rdata[15:11];
            funct_d  = imem_rdata[3:0];
        end
        // PC wraps modulo 2^PC_W rather than back to RESET_PC.
        if (state_q == S_WB) begin
            pc_d      = pc_q + PC_STEP;
            retired_d = retired_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            retired_q <= '0;
            opcode_q  <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            funct_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            retired_q <= retired_d;
            opcode_q  <= opcode_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            funct_q   <= funct_d;
        end
    end

    // Outputs decode straight from the registered state so an async reset
    // clears them without waiting for a clock edge.
    always_comb begin
        imem_req = (state_q == S_FETCH);
        rf_we    = (state_q == S_WB);
        alu_op   = (state_q == S_EXEC) ? funct_q : ALU_IDLE;
        busy     = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                   (state_q == S_EXEC)  || (state_q == S_WB);
        halted   = (state_q == S_HALT);
    end

    assign imem_addr  = pc_q;
    assign rf_rs_addr = rs_q;
    assign rf_rt_addr = rt_q;
    assign rf_rd_addr = rd_q;
    assign retired    = retired_q;

endmodule
